// File: rtl/mmio_map_pkg.sv
`default_nettype none
// ============================================================================
// Module : mmio_map_pkg
// Brief  : Memory-map constants, slave indices and FSM state type for the
//          MMIO bus decoder.
// Rev    : 1.0 - initial release
// ============================================================================
package mmio_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int N_MAP     = 5;
    localparam int SLV_MEM   = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_GAUSS = 2;
    localparam int SLV_LEDS  = 3;
    localparam int SLV_SEG7  = 4;

    // Packed arrays: rightmost element is index 0.
    localparam logic [N_MAP-1:0][31:0] BASE = {
        32'h0000_2008, 32'h0000_2004, 32'h0000_2030, 32'h0000_2010, 32'h0000_1000
    };
    localparam logic [N_MAP-1:0][31:0] MASK = {
        32'h0000_F00F, 32'h0000_F00F, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F000
    };
    localparam logic [N_MAP-1:0][2:0] WAIT_ST = {
        3'd0, 3'd0, 3'd3, 3'd1, 3'd0
    };

endpackage
`default_nettype wire

// File: rtl/mmio_addr_match.sv
`default_nettype none
// ============================================================================
// Module : mmio_addr_match
// Brief  : Combinational base/mask decode; lowest matching index wins.
// Rev    : 1.0 - initial release
// ============================================================================
module mmio_addr_match
    import mmio_map_pkg::*;
#(
    parameter int N_SLV  = 5,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((addr_i & MASK[k][ADDR_W-1:0]) == BASE[k][ADDR_W-1:0]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module : mmio_bus_decoder
// Brief  : MMIO decoder with per-slave strobes, wait states and a sticky
//          unmapped-access capture enabled by DECODER_ERR_CAPTURE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module mmio_bus_decoder
    import mmio_map_pkg::*;
#(
    parameter int N_SLV  = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          we_i,
    input  logic                          re_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          ack_o,
    output logic                          stall_o,
    output logic [N_SLV-1:0]              we_o,
    output logic [N_SLV-1:0]              re_o,
    output logic [DATA_W-1:0]             wdata_o,
    input  logic [N_SLV-1:0][DATA_W-1:0]  rdata_s_i,
    output logic                          err_o,
    output logic [ADDR_W-1:0]             err_addr_o,
    input  logic                          err_clr_i
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                op_we_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                w_req;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic                w_accept;
    logic [WAIT_W-1:0]   w_wait_st;
    logic [N_SLV-1:0]    w_onehot;

    mmio_addr_match #(
        .N_SLV  (N_SLV),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .addr_i (addr_i),
        .hit_o  (w_hit),
        .idx_o  (w_idx)
    );

    assign w_req     = we_i | re_i;
    assign w_accept  = (state_q == ST_IDLE) && w_req;
    assign w_wait_st = WAIT_W'(WAIT_ST[idx_q]);
    assign w_onehot  = N_SLV'(1) << idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) state_d = w_hit ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                if (w_wait_st != '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = w_wait_st - WAIT_W'(1);
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - WAIT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_we_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                op_we_q <= we_i;
                idx_q   <= w_idx;
                wdata_q <= wdata_i;
            end
            // Unmapped accesses reach RESP straight from IDLE and read as 0.
            if (state_d == ST_RESP && state_q != ST_RESP) begin
                rdata_q <= (state_q != ST_IDLE && !op_we_q) ? rdata_s_i[idx_q] : '0;
            end
        end
    end

    // Outputs are gated with rst so an aborted access never strobes a slave.
    assign we_o    = (!rst && state_q == ST_ACCESS &&  op_we_q) ? w_onehot : '0;
    assign re_o    = (!rst && state_q == ST_ACCESS && !op_we_q) ? w_onehot : '0;
    assign ack_o   = !rst && (state_q == ST_RESP);
    assign stall_o = !rst && (w_accept || state_q == ST_ACCESS || state_q == ST_WAIT);
    assign rdata_o = rdata_q;
    assign wdata_o = wdata_q;

`ifdef DECODER_ERR_CAPTURE_EN
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              w_miss;

    assign w_miss = w_accept && !w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (w_miss) begin
            err_q <= 1'b1;
            if (!err_q || err_clr_i) err_addr_q <= addr_i;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr_i;
    assign err_o            = 1'b0;
    assign err_addr_o       = '0;
`endif

endmodule
`default_nettype wire
